// File: rtl/fwft_rd_pkg.sv
// Shared types and helpers for the fwft read-side serializer.
package fwft_rd_pkg;

    typedef enum logic {IDLE, SHIFT} rd_state_t;

    function automatic int ratio(int dw, int ow);
        return dw / ow;
    endfunction

endpackage

// File: rtl/fwft_rd_serializer.sv
// Pops words from an fwft FIFO and emits each as RATIO LSB-first beats on a valid/ready stream.
// Optional feature: define FWFT_RD_PARITY_EN to add the out_par port (registered ^out_data).
module fwft_rd_serializer
    import fwft_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    output logic                  rd,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last
`ifdef FWFT_RD_PARITY_EN
    ,
    output logic                  out_par
`endif
);

    localparam int unsigned Ratio = ratio(DATA_WIDTH, OUT_WIDTH);
    localparam int unsigned CntW  = $clog2(Ratio);

    if ((DATA_WIDTH % OUT_WIDTH) != 0 || Ratio < 2) begin : g_param_err
        $error("fwft_rd_serializer: DATA_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end

    rd_state_t             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  accept, load;

    assign accept    = (state_q == SHIFT) && out_ready;
    // Reload on the final accepted beat so consecutive words stream without a bubble.
    assign load      = !empty && ((state_q == IDLE) || (accept && out_last_q));
    assign rd        = load && !arst;
    assign cnt_inc   = cnt_q + 1'b1;
    assign out_valid = (state_q == SHIFT);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (load) begin
            state_d    = SHIFT;
            cnt_d      = '0;
            shreg_d    = rd_data;
            out_data_d = rd_data[OUT_WIDTH-1:0];
            out_last_d = 1'b0;
        end else if (accept) begin
            if (out_last_q) begin
                state_d = IDLE;
            end else begin
                cnt_d      = cnt_inc;
                out_data_d = shreg_q[cnt_inc*OUT_WIDTH +: OUT_WIDTH];
                out_last_d = (cnt_inc == CntW'(Ratio - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

`ifdef FWFT_RD_PARITY_EN
    logic out_par_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= ^out_data_d;
        end
    end

    assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_fwft_rd_serializer.sv
// Self-checking bench: directed scenarios then random traffic against a beat-queue model.
module tb_fwft_rd_serializer;

    localparam int DW = 32;
    localparam int OW = 8;
    localparam int R  = DW / OW;

    logic          clk = 1'b0;
    logic          arst;
    logic          rd;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
`ifdef FWFT_RD_PARITY_EN
    logic          out_par;
`endif

    fwft_rd_serializer #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .rd        (rd),
        .rd_data   (rd_data),
        .empty     (empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef FWFT_RD_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo[$];
    logic [OW-1:0] beats[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: present FIFO head, check outputs vs model, advance model over the edge.
    task automatic tick();
        logic          exp_rd;
        logic          acc;
        logic [DW-1:0] w;
        empty   = (fifo.size() == 0);
        rd_data = (fifo.size() != 0) ? fifo[0] : DW'($urandom);
        #1;
        exp_rd = !arst && (fifo.size() != 0) &&
                 ((beats.size() == 0) || (out_ready && beats.size() == 1));
        check("rd", 32'(rd), 32'(exp_rd));
        check("out_valid", 32'(out_valid), 32'(beats.size() != 0));
        if (beats.size() != 0) begin
            check("out_data", 32'(out_data), 32'(beats[0]));
            check("out_last", 32'(out_last), 32'(beats.size() == 1));
`ifdef FWFT_RD_PARITY_EN
            check("out_par", 32'(out_par), 32'(^beats[0]));
`endif
        end
        if (arst) begin
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_last", 32'(out_last), 32'd0);
        end
        acc = out_ready && (beats.size() != 0) && !arst;
        @(posedge clk);
        if (arst) begin
            beats.delete();
        end else begin
            if (acc) void'(beats.pop_front());
            if (exp_rd) begin
                w = fifo.pop_front();
                for (int k = 0; k < R; k++) beats.push_back(w[k*OW +: OW]);
            end
        end
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        arst      = 1'b1;
        out_ready = 1'b1;
        empty     = 1'b1;
        rd_data   = '0;
        @(negedge clk);

        // Reset held with a word waiting; then that word streams out.
        fifo.push_back(32'hA1B2C3D4);
        ticks(3);
        arst = 1'b0;
        ticks(6);

        // Two queued words stream back to back.
        fifo.push_back(32'h0BADF00D);
        fifo.push_back(32'hCAFEBABE);
        ticks(10);

        // Stall mid-word.
        fifo.push_back(32'h12345678);
        ticks(2);
        out_ready = 1'b0;
        ticks(3);
        out_ready = 1'b1;
        ticks(5);

        // Empty throughout.
        ticks(5);

        // Async reset mid-word, then a clean word.
        fifo.push_back(32'h11223344);
        ticks(3);
        arst = 1'b1;
        beats.delete();
        ticks(2);
        arst = 1'b0;
        fifo.push_back(32'h55667788);
        ticks(6);

        // Random traffic and backpressure.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo.size() < 8) fifo.push_back($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        out_ready = 1'b1;
        ticks(40);
        check("drained_fifo", 32'(fifo.size()), 32'd0);
        check("drained_beats", 32'(beats.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
